// File: rtl/xoodoo_perm_engine.sv
// Xoodoo[n] permutation engine with valid/ready handshakes.
// RPC rounds are unrolled per clock. The round count n is chosen at run time
// and applied as the last n rounds of Xoodoo[12] (constants C[12-n..11]).
// An illegal n runs as n=12 and reports cfg_err together with the result.
// Optional feature macro: XOODOO_ABORT_EN adds an 'abort' input. When abort is
// high in RUN or DONE, the engine drops its work and returns to IDLE.
module xoodoo_perm_engine #(
    parameter int RPC        = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         eph1,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [383:0] state_in,
    input  logic [3:0]   nr_rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [383:0] state_out,
    output logic         cfg_err,
`ifdef XOODOO_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 3 || RPC == 4 || RPC == 6 || RPC == 12)) begin : g_bad_rpc
            $error("xoodoo_perm_engine: RPC must be one of 1, 2, 3, 4, 6, 12");
        end
        if (MAX_ROUNDS != 12) begin : g_bad_max_rounds
            $error("xoodoo_perm_engine: MAX_ROUNDS must be 12");
        end
    endgenerate

    localparam logic [3:0] RPC_L  = 4'(RPC);
    localparam logic [3:0] LAST_K = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [383:0] lanes_q, lanes_d;
    logic [3:0]   k_q, k_d;
    logic         cfg_err_q, cfg_err_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [383:0] rounds_s;
    logic         n_legal_s;
    logic [3:0]   k_start_s;
    logic         last_step_s;
    logic         abort_s;

    // Round constant C[idx]; out-of-range indices never occur in RUN.
    function automatic logic [31:0] round_const(input logic [3:0] idx);
        logic [31:0] c;
        case (idx)
            4'd0:    c = 32'h0000_0058;
            4'd1:    c = 32'h0000_0038;
            4'd2:    c = 32'h0000_03C0;
            4'd3:    c = 32'h0000_00D0;
            4'd4:    c = 32'h0000_0120;
            4'd5:    c = 32'h0000_0014;
            4'd6:    c = 32'h0000_0060;
            4'd7:    c = 32'h0000_002C;
            4'd8:    c = 32'h0000_0380;
            4'd9:    c = 32'h0000_00F0;
            4'd10:   c = 32'h0000_01A0;
            4'd11:   c = 32'h0000_0012;
            default: c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    // 32-bit rotate left by a constant amount in 1..31.
    function automatic logic [31:0] rol32(input logic [31:0] v, input int amt);
        return (v << amt) | (v >> (32 - amt));
    endfunction

    // Byte-string order <-> lane order. Lane i holds bytes 4i..4i+3 little-endian,
    // so the whole conversion is a reversal of the 48 bytes (its own inverse).
    function automatic logic [383:0] swap_bytes(input logic [383:0] v);
        logic [383:0] r;
        for (int j = 0; j < 48; j++) begin
            r[8*j +: 8] = v[383-8*j -: 8];
        end
        return r;
    endfunction

    // One Xoodoo round on the lane-ordered state; lane (x,y) sits at index x+4y.
    function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] rc);
        logic [31:0]  a [12];
        logic [31:0]  w [12];
        logic [31:0]  p [4];
        logic [31:0]  e [4];
        logic [383:0] r;
        for (int i = 0; i < 12; i++) begin
            a[i] = s[32*i +: 32];
        end
        // theta: column parity folded back with shifts (1,5) and (1,14)
        for (int x = 0; x < 4; x++) begin
            p[x] = a[x] ^ a[4+x] ^ a[8+x];
        end
        for (int x = 0; x < 4; x++) begin
            e[x] = rol32(p[(x+3)%4], 5) ^ rol32(p[(x+3)%4], 14);
        end
        for (int i = 0; i < 12; i++) begin
            a[i] = a[i] ^ e[i%4];
        end
        // rho-west: plane1 by (1,0), plane2 by (0,11)
        for (int x = 0; x < 4; x++) begin
            w[x]   = a[x];
            w[4+x] = a[4+((x+3)%4)];
            w[8+x] = rol32(a[8+x], 11);
        end
        // iota
        w[0] = w[0] ^ rc;
        // chi
        for (int x = 0; x < 4; x++) begin
            a[x]   = w[x]   ^ (~w[4+x] & w[8+x]);
            a[4+x] = w[4+x] ^ (~w[8+x] & w[x]);
            a[8+x] = w[8+x] ^ (~w[x]   & w[4+x]);
        end
        // rho-east: plane1 by (0,1), plane2 by (2,8)
        for (int x = 0; x < 4; x++) begin
            r[32*x +: 32]     = a[x];
            r[32*(4+x) +: 32] = rol32(a[4+x], 1);
            r[32*(8+x) +: 32] = rol32(a[8+((x+2)%4)], 8);
        end
        return r;
    endfunction

`ifdef XOODOO_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Validate requested round count and derive the starting round index.
    always_comb begin
        n_legal_s = 1'b0;
        k_start_s = 4'd0;
        if ((nr_rounds >= RPC_L) && (nr_rounds <= LAST_K) && ((nr_rounds % RPC_L) == 4'd0)) begin
            n_legal_s = 1'b1;
            k_start_s = LAST_K - nr_rounds;
        end else begin
            n_legal_s = 1'b0;
            k_start_s = 4'd0;
        end
    end

    // Unrolled datapath: RPC consecutive rounds starting at constant index k.
    always_comb begin
        rounds_s = lanes_q;
        for (int r = 0; r < RPC; r++) begin
            rounds_s = xoodoo_round(rounds_s, round_const(k_q + 4'(r)));
        end
    end

    assign last_step_s = (({1'b0, k_q} + {1'b0, RPC_L}) >= {1'b0, LAST_K});

    // FSM next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        k_d         = k_q;
        cfg_err_d   = cfg_err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = RUN;
                    lanes_d     = swap_bytes(state_in);
                    k_d         = k_start_s;
                    cfg_err_d   = ~n_legal_s;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_d     = IDLE;
                    cfg_err_d   = 1'b0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    lanes_d = rounds_s;
                    k_d     = k_q + RPC_L;
                    if (last_step_s) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (abort_s) begin
                    state_d     = IDLE;
                    cfg_err_d   = 1'b0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                k_d         = 4'd0;
                cfg_err_d   = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lanes_q     <= 384'd0;
            k_q         <= 4'd0;
            cfg_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            k_q         <= k_d;
            cfg_err_q   <= cfg_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign state_out = swap_bytes(lanes_q);

endmodule

// File: tb/tb_xoodoo_perm_engine.sv
// Scoreboard bench for xoodoo_perm_engine: three instances (RPC = 1, 2, 4)
// share clock and reset; each operation pushes its expected result into a queue
// and a monitor pops and compares on every output handshake.
module tb_xoodoo_perm_engine;

    localparam logic [31:0] RC_TB [12] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    typedef struct {
        int           id;
        logic [383:0] st;
        logic         cfg;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic         cfg  [3];
    logic         bsy  [3];
    logic         ab   [3];
    logic [383:0] sin  [3];
    logic [383:0] sout [3];
    logic [3:0]   nr   [3];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];
    logic ov_prev [3];
    int   rise_cyc [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            xoodoo_perm_engine #(.RPC((g == 0) ? 1 : ((g == 1) ? 2 : 4))) u_dut (
                .eph1      (clk),
                .reset_n   (rst_n),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .state_in  (sin[g]),
                .nr_rounds (nr[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .state_out (sout[g]),
                .cfg_err   (cfg[g]),
`ifdef XOODOO_ABORT_EN
                .abort     (ab[g]),
`endif
                .busy      (bsy[g])
            );
        end
    endgenerate

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference Xoodoo[nr] on a byte-string state, using planes a[y][x].
    function automatic logic [383:0] ref_perm(input logic [383:0] bs, input int nrr);
        logic [31:0]  a [3][4];
        logic [31:0]  b [3][4];
        logic [31:0]  p [4];
        logic [31:0]  e [4];
        logic [31:0]  t [4];
        logic [383:0] o;
        int           i;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                i = x + 4*y;
                a[y][x] = {bs[383-8*(4*i+3) -: 8], bs[383-8*(4*i+2) -: 8],
                           bs[383-8*(4*i+1) -: 8], bs[383-8*(4*i) -: 8]};
            end
        end
        for (int r = 12 - nrr; r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
            for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
            for (int x = 0; x < 4; x++) t[x] = a[1][x];
            for (int x = 0; x < 4; x++) a[1][x] = t[(x+3)%4];
            for (int x = 0; x < 4; x++) a[2][x] = rotl(a[2][x], 11);
            a[0][0] = a[0][0] ^ RC_TB[r];
            for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
            for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
            for (int x = 0; x < 4; x++) a[1][x] = rotl(a[1][x], 1);
            for (int x = 0; x < 4; x++) t[x] = a[2][x];
            for (int x = 0; x < 4; x++) a[2][x] = rotl(t[(x+2)%4], 8);
        end
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                i = x + 4*y;
                o[383-8*(4*i) -: 8]   = a[y][x][7:0];
                o[383-8*(4*i+1) -: 8] = a[y][x][15:8];
                o[383-8*(4*i+2) -: 8] = a[y][x][23:16];
                o[383-8*(4*i+3) -: 8] = a[y][x][31:24];
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pops and compares the expected record on every out_valid & out_ready.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ov[i] === 1'b1 && ov_prev[i] !== 1'b1) rise_cyc[i] = cyc;
                ov_prev[i] = ov[i];
                if (ov[i] === 1'b1 && ordy[i] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chki("unexpected_output_inst", i, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chki("result_instance", i, e.id);
                        chk("state_out", sout[i], e.st);
                        chkb("cfg_err", cfg[i], e.cfg);
                        chki("latency", rise_cyc[i] - e.acc, e.lat);
                    end
                end
            end
        end
    endtask

    // Presents one input, waits (bounded) for acceptance, optionally scores it.
    task automatic issue(input int id, input logic [383:0] st, input logic [3:0] n,
                         input bit push, input int lat, input logic ecfg, input int eff_n);
        int   waited;
        exp_t e;
        @(negedge clk);
        iv[id]  = 1'b1;
        sin[id] = st;
        nr[id]  = n;
        waited  = 0;
        while (ir[id] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (ir[id] !== 1'b1) begin
            chkb("accept_timeout", ir[id], 1'b1);
            iv[id] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            iv[id] = 1'b0;
            if (push) begin
                e.id  = id;
                e.st  = ref_perm(st, eff_n);
                e.cfg = ecfg;
                e.lat = lat;
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chki("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input int id, input logic [383:0] st, input logic [3:0] n,
                          input int lat, input logic ecfg, input int eff_n);
        issue(id, st, n, 1'b1, lat, ecfg, eff_n);
        drain();
    endtask

    logic [383:0] s_zero, s_inc, s_rnd, s_a, s_b;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; ab[i] = 1'b0; sin[i] = 384'd0; nr[i] = 4'd0;
            ov_prev[i] = 1'b0; rise_cyc[i] = 0;
        end
        s_zero = 384'd0;
        for (int j = 0; j < 48; j++) s_inc[383-8*j -: 8] = 8'(j);
        for (int j = 0; j < 12; j++) s_rnd[32*j +: 32] = $urandom;
        for (int j = 0; j < 12; j++) s_a[32*j +: 32] = $urandom;
        for (int j = 0; j < 12; j++) s_b[32*j +: 32] = $urandom;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chkb("reset_in_ready", ir[i], 1'b1);
            chkb("reset_out_valid", ov[i], 1'b0);
            chkb("reset_busy", bsy[i], 1'b0);
            chkb("reset_cfg_err", cfg[i], 1'b0);
            chk("reset_state_out", sout[i], 384'd0);
        end
        rst_n = 1'b1;
        fork monitor_loop(); join_none

        // Main function, several patterns and round counts
        run_op(0, s_zero, 4'd12, 12, 1'b0, 12);
        run_op(2, s_inc,  4'd12, 3,  1'b0, 12);
        run_op(0, s_inc,  4'd12, 12, 1'b0, 12);
        run_op(1, s_rnd,  4'd6,  3,  1'b0, 6);
        run_op(0, s_rnd,  4'd3,  3,  1'b0, 3);
        // Illegal round counts run as 12 rounds with cfg_err
        run_op(2, s_rnd,  4'd6,  3,  1'b1, 12);
        run_op(0, s_inc,  4'd0,  12, 1'b1, 12);
        run_op(1, s_zero, 4'd13, 6,  1'b1, 12);
        run_op(1, s_inc,  4'd5,  6,  1'b1, 12);

        // busy during RUN
        issue(0, s_a, 4'd12, 1'b1, 12, 1'b0, 12);
        @(negedge clk);
        chkb("busy_in_run", bsy[0], 1'b1);
        chkb("in_ready_in_run", ir[0], 1'b0);
        drain();

        // Back-pressure with a second input held during RUN and DONE
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        issue(0, s_a, 4'd12, 1'b1, 12, 1'b0, 12);
        fork
            issue(0, s_b, 4'd12, 1'b1, 12, 1'b0, 12);
            begin
                int n = 0;
                while (ov[0] !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chkb("stall_reached_done", ov[0], 1'b1);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    chk("stall_state_out", sout[0], ref_perm(s_a, 12));
                    chkb("stall_in_ready", ir[0], 1'b0);
                    chkb("stall_out_valid", ov[0], 1'b1);
                end
                @(posedge clk);
                #1 ordy[0] = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chkb("hs_in_ready_next", ir[0], 1'b1);
                chkb("hs_out_valid_drop", ov[0], 1'b0);
            end
        join
        drain();

        // Reset pulsed mid-RUN discards the operation
        issue(0, s_a, 4'd12, 1'b0, 12, 1'b0, 12);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkb("rst_mid_in_ready", ir[0], 1'b1);
        chkb("rst_mid_out_valid", ov[0], 1'b0);
        chkb("rst_mid_busy", bsy[0], 1'b0);
        chk("rst_mid_state_out", sout[0], 384'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, s_b, 4'd12, 12, 1'b0, 12);

`ifdef XOODOO_ABORT_EN
        // Abort mid-RUN behaves like the reset case, then a fresh run completes
        issue(0, s_a, 4'd12, 1'b0, 12, 1'b0, 12);
        repeat (5) @(negedge clk);
        ab[0] = 1'b1;
        @(posedge clk);
        #1 ab[0] = 1'b0;
        chkb("abort_in_ready", ir[0], 1'b1);
        chkb("abort_out_valid", ov[0], 1'b0);
        chkb("abort_cfg_err", cfg[0], 1'b0);
        repeat (15) @(negedge clk);
        chkb("abort_no_result", ov[0], 1'b0);
        run_op(0, s_inc, 4'd12, 12, 1'b0, 12);
`endif

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
